// File: rtl/arb2_rr_sel.sv
// Two-requester round-robin arbiter driving a registered 2:1 mux select.
// Optional forced release after MAX_HOLD cycles with macro ARB_TIMEOUT_EN.
module arb2_rr_sel #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic done,
  output logic s,
  output logic gnt0,
  output logic gnt1,
  output logic busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic timeout
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t             state, state_n;
  logic               last, last_n;
  logic               s_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               req_own;
  logic               rel;
  logic               tmo_hit;

  if (MAX_HOLD < 2 || MAX_HOLD > 255 ||
      (1 << CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("arb2_rr_sel: illegal MAX_HOLD/CNT_W");
  end

  always_comb begin
    req_own = (state == OWN1) ? req1 : req0;
`ifdef ARB_TIMEOUT_EN
    tmo_hit = (state != IDLE) && req_own && !done &&
              (cnt == CNT_W'(MAX_HOLD - 1));
`else
    tmo_hit = 1'b0;
`endif
    rel = (state != IDLE) &&
          (done || !req_own || tmo_hit);

    last_n = last;
    if (rel) last_n = (state == OWN1);

    // Re-arbitrate with the updated pointer so a handover has no bubble
    state_n = state;
    if (state == IDLE || rel) begin
      unique case (1'b1)
        (req0 && req1):  state_n = last_n ? OWN0 : OWN1;
        (req0 && !req1): state_n = OWN0;
        (!req0 && req1): state_n = OWN1;
        default:         state_n = IDLE;
      endcase
    end

    s_n = s;
    if (state_n == OWN0) s_n = 1'b0;
    else if (state_n == OWN1) s_n = 1'b1;

    cnt_n = cnt;
    if (state_n == IDLE || state == IDLE || rel)
      cnt_n = '0;
    else if (cnt != '1)
      cnt_n = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      s     <= 1'b0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      s     <= s_n;
      gnt0  <= (state_n == OWN0);
      gnt1  <= (state_n == OWN1);
      busy  <= (state_n != IDLE);
      cnt   <= cnt_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout <= 1'b0;
    else        timeout <= tmo_hit;
  end
`endif

endmodule

// File: tb/tb_arb2_rr_sel.sv
// Bench for arb2_rr_sel: directed scenarios plus random traffic
// checked against an ownership-level reference model.
module tb_arb2_rr_sel;

`ifdef ARB_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 16;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic done = 1'b0;
  logic s, gnt0, gnt1, busy;
  logic timeout;

  int checks = 0;
  int errors = 0;

  // reference model: owner -1 = nobody
  int m_own;
  int m_last;
  int m_hold;
  bit m_s;
  bit m_tmo;

  always #5 clk = ~clk;

  arb2_rr_sel #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req0(req0),
    .req1(req1),
    .done(done),
    .s(s),
    .gnt0(gnt0),
    .gnt1(gnt1),
`ifdef ARB_TIMEOUT_EN
    .busy(busy),
    .timeout(timeout)
`else
    .busy(busy)
`endif
  );

`ifndef ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  task automatic model_reset();
    m_own  = -1;
    m_last = 1;
    m_hold = 0;
    m_s    = 1'b0;
    m_tmo  = 1'b0;
  endtask

  task automatic model_step(input bit r0, input bit r1, input bit d);
    bit rel;
    bit ro;
    rel   = 1'b0;
    m_tmo = 1'b0;
    if (m_own >= 0) begin
      ro = (m_own == 1) ? r1 : r0;
      if (d || !ro) rel = 1'b1;
`ifdef ARB_TIMEOUT_EN
      else if (m_hold == MH - 1) begin
        rel   = 1'b1;
        m_tmo = 1'b1;
      end
`endif
    end
    if (m_own < 0 || rel) begin
      if (rel) m_last = m_own;
      if (r0 && r1) m_own = 1 - m_last;
      else if (r0) m_own = 0;
      else if (r1) m_own = 1;
      else m_own = -1;
      m_hold = 0;
    end else begin
      m_hold++;
    end
    if (m_own >= 0) m_s = (m_own == 1);
  endtask

  function automatic logic [4:0] model_vec();
    return {m_s, m_own == 0, m_own == 1, m_own >= 0, m_tmo};
  endfunction

  // one clock: apply inputs, edge, advance model, settle
  task automatic cyc(input bit r0, input bit r1, input bit d);
    req0 = r0;
    req1 = r1;
    done = d;
    @(posedge clk);
    if (rst_n) model_step(r0, r1, d);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({s, gnt0, gnt1, busy, timeout} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state got %b want 00000",
               {s, gnt0, gnt1, busy, timeout});
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0);
      checks++;
      if ({s, gnt0, gnt1, busy, timeout} !== 5'b0) begin
        errors++;
        $display("FAIL idle_%0d got %b want 00000", i,
                 {s, gnt0, gnt1, busy, timeout});
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    cyc(1, 1, 0);
    checks++;
    if ({s, gnt0, gnt1} !== 3'b010) begin
      errors++;
      $display("FAIL first_tie got s/g0/g1 %b want 010",
               {s, gnt0, gnt1});
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, (i == 2 || i == 4));
      checks++;
      if ({s, gnt0, gnt1, busy, timeout} !== model_vec()) begin
        errors++;
        $display("FAIL simul_%0d got %b want %b", i,
                 {s, gnt0, gnt1, busy, timeout}, model_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, (i % 3 == 2));
      if (i > 0) begin
        checks++;
        if ({s, gnt0, gnt1, busy} !== 4'b1011 ||
            {s, gnt0, gnt1, busy, timeout} !== model_vec()) begin
          errors++;
          $display("FAIL b2b_%0d got %b want %b", i,
                   {s, gnt0, gnt1, busy, timeout}, model_vec());
        end
      end
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cyc(i < 6, i >= 9, 0);
      checks++;
      if ({s, gnt0, gnt1, busy, timeout} !== model_vec()) begin
        errors++;
        $display("FAIL drop_%0d got %b want %b", i,
                 {s, gnt0, gnt1, busy, timeout}, model_vec());
      end
    end
    checks++;
    if ({s, gnt1} !== 2'b11) begin
      errors++;
      $display("FAIL drop_regrant got s/g1 %b want 11", {s, gnt1});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({s, gnt0, gnt1, busy, timeout} !== 5'b0) begin
      errors++;
      $display("FAIL async_rst got %b want 00000",
               {s, gnt0, gnt1, busy, timeout});
    end
    cyc(1, 1, 0);
    rst_n = 1'b1;
    cyc(1, 1, 0);
    checks++;
    if ({s, gnt0, gnt1, busy} !== 4'b0101) begin
      errors++;
      $display("FAIL post_rst_tie got %b want 0101",
               {s, gnt0, gnt1, busy});
    end
  endtask

  task automatic test_random();
    bit r0, r1, d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 4) == 0);
      cyc(r0, r1, d);
      checks++;
      if ({s, gnt0, gnt1, busy, timeout} !== model_vec()) begin
        errors++;
        $display("FAIL rand_%0d got %b want %b", i,
                 {s, gnt0, gnt1, busy, timeout}, model_vec());
      end
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [4:0] pat [10];
    pat = '{5'b01010, 5'b01010, 5'b01010, 5'b01010,
            5'b10111, 5'b10110, 5'b10110, 5'b10110,
            5'b01011, 5'b01010};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0);
      checks++;
      if ({s, gnt0, gnt1, busy, timeout} !== pat[i]) begin
        errors++;
        $display("FAIL tmo_%0d got %b want %b", i,
                 {s, gnt0, gnt1, busy, timeout}, pat[i]);
      end
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_simultaneous();
    test_back_to_back();
    test_req_drop();
    test_async_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
